// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- generic pipeline stage register with valid/ready handshake.
//
// One instance sits between each pair of CPU pipeline stages and carries an
// arbitrary packed bundle (PC, instruction, control). Downstream back-pressure
// stalls the stage; `flush` squashes everything held or arriving this cycle.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   : two-entry skid buffer, registered in_ready
//                       undefined : single entry, in_ready = out_ready | ~out_valid
//
// Parameters:
//   DATA_W  width of the carried bundle
//   BUBBLE  value on out_data whenever out_valid = 0 (all-zero = NOP)
//   CNT_W   width of the saturating flush discard counter
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      squash held and incoming words this cycle
//   in_valid   upstream word present
//   in_ready   stage accepts a word this cycle
//   in_data    upstream word
//   out_valid  out_data holds a live word
//   out_ready  downstream consumes the word this cycle
//   out_data   registered word to the next stage
//   flush_cnt  saturating count of valid words discarded by flush

module pipe_stage_reg #(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              in_fire;
    logic              out_fire;
    logic [1:0]        drop_cnt;   // valid words discarded if flush is high
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W+1:0]  cnt_sum;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Saturating add, two guard bits so the sum can never wrap before compare.
    always_comb begin
        cnt_sum     = {2'b00, flush_cnt_q} + {{CNT_W{1'b0}}, drop_cnt};
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            if (cnt_sum > {2'b00, {CNT_W{1'b1}}})
                flush_cnt_d = {CNT_W{1'b1}};
            else
                flush_cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flush_cnt_q <= '0;
        else       flush_cnt_q <= flush_cnt_d;
    end

    assign flush_cnt = flush_cnt_q;

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        held;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path matters.
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = BUBBLE;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = BUBBLE;
                skid_d  = BUBBLE;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // Held words minus the one leaving downstream plus any accepted one.
    always_comb begin
        case (state_q)
            ONE:     held = 2'd1;
            FULL:    held = 2'd2;
            default: held = 2'd0;
        endcase
        drop_cnt = held + {1'b0, in_fire} - {1'b0, out_fire};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`else

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    // Combinational ready: a word may enter when the slot is free or leaving.
    assign in_ready = out_ready | ~out_valid_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = BUBBLE;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_data_d  = BUBBLE;
        end
        drop_cnt = {1'b0, out_valid_q & ~out_ready} + {1'b0, in_fire};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= BUBBLE;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a negedge monitor keeps a scoreboard
// queue of words the stage should hold and a model of the discard counter.

module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  flush_cnt;

    pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE('0), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard model
    logic [DATA_W-1:0] sb[$];
    int                mcnt  = 0;
    bit                mfire = 1'b0;

    always @(negedge clk) begin
        bit exp_rdy, ifire, ofire;
        if (reset) begin
            sb.delete();
            mcnt  = 0;
            mfire = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data",  out_data,  0);
            chk("rst_flush_cnt", flush_cnt, 0);
            chk("rst_in_ready",  in_ready,  1);
        end else begin
            exp_rdy = SKID ? (sb.size() < 2) : (out_ready || sb.size() == 0);
            chk("in_ready",  in_ready,  exp_rdy);
            chk("out_valid", out_valid, sb.size() != 0);
            chk("out_data",  out_data,  (sb.size() != 0) ? sb[0] : 64'h0);
            chk("flush_cnt", flush_cnt, (mcnt > MAXC) ? MAXC : mcnt);
            ifire = in_valid && exp_rdy;
            ofire = out_ready && (sb.size() != 0);
            if (ofire) void'(sb.pop_front());
            if (flush) begin
                mcnt += sb.size() + int'(ifire);
                sb.delete();
            end else if (ifire) begin
                sb.push_back(in_data);
            end
            mfire = ifire;
        end
    end

    task automatic step(input logic v, input logic [63:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    // Send three words, out_ready held low for `stall` cycles, then drain.
    task automatic send3(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input int stall);
        logic [63:0] w[3];
        int i;
        int cyc;
        w[0] = a; w[1] = b; w[2] = c;
        i = 0;
        cyc = 0;
        while (cyc < 40 && (i < 3 || sb.size() != 0)) begin
            step(i < 3, (i < 3) ? w[i] : 64'h0, cyc >= stall, 0);
            if (mfire) i++;
            cyc++;
        end
        chk("send3_done", (i == 3 && sb.size() == 0), 1);
        step(0, 0, 1, 0);
    endtask

    initial begin
        logic [CNT_W-1:0] sat_exp[4];
        int               nsat;

        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Release with a word pending: accepted on the first edge after release.
        reset = 1'b0;
        step(1, 64'hDEAD, 0, 0);
        chk("dead_valid", out_valid, 1);
        chk("dead_data",  out_data,  64'hDEAD);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Streaming, then stall
        send3(64'h1, 64'h2, 64'h3, 0);
        send3(64'h10, 64'h11, 64'h12, 3);
        chk("after_stream_valid", out_valid, 0);
        chk("after_stream_data",  out_data,  0);

        // Flush with main (and skid) occupied
        do_reset();
        step(1, 64'hA, 0, 0);
        step(1, 64'hB, 0, 0);
        step(0, 0, 0, 1);
        chk("flushfull_valid", out_valid, 0);
        chk("flushfull_rdy",   in_ready,  1);
        chk("flushfull_cnt",   flush_cnt, SKID ? 2 : 1);
        step(0, 0, 1, 0);

        // Flush with an incoming word in the same cycle
        do_reset();
        step(1, 64'hB0, 0, 0);
        step(1, 64'hC, 0, 1);
        chk("flushin_cnt", flush_cnt, SKID ? 2 : 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Asynchronous reset clears a held word before the next edge
        step(1, 64'h55, 0, 0);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data",  out_data,  0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 0, 1, 0);

        // Counter saturation at 2^CNT_W-1
        do_reset();
        if (SKID) begin
            sat_exp[0] = 2; sat_exp[1] = 3; sat_exp[2] = 3; sat_exp[3] = 3; nsat = 3;
        end else begin
            sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; nsat = 4;
        end
        for (int k = 0; k < nsat; k++) begin
            step(1, 64'h100 + 64'(k), 0, 0);
            if (SKID) step(1, 64'h200 + 64'(k), 0, 0);
            step(0, 0, 0, 1);
            chk("sat_cnt", flush_cnt, sat_exp[k]);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
